// File: rtl/aes_pkg.sv
// Shared AES types and byte-level helpers for the round datapath.
// A state is four 32-bit columns; row r of a column sits in bits [8r+7:8r].
package aes_pkg;

  typedef logic [31:0] aes_col_t;
  typedef aes_col_t [3:0] aes_state_t;

  localparam logic [7:0] AES_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Output column c, row r takes input column (c+r) mod 4, row r.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o[0] = {s[3][31:24], s[2][23:16], s[1][15:8], s[0][7:0]};
    o[1] = {s[0][31:24], s[3][23:16], s[2][15:8], s[1][7:0]};
    o[2] = {s[1][31:24], s[0][23:16], s[3][15:8], s[2][7:0]};
    o[3] = {s[2][31:24], s[1][23:16], s[0][15:8], s[3][7:0]};
    return o;
  endfunction

  // Output column c, row r takes input column (c-r) mod 4, row r.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o[0] = {s[1][31:24], s[2][23:16], s[3][15:8], s[0][7:0]};
    o[1] = {s[2][31:24], s[3][23:16], s[0][15:8], s[1][7:0]};
    o[2] = {s[3][31:24], s[0][23:16], s[1][15:8], s[2][7:0]};
    o[3] = {s[0][31:24], s[1][23:16], s[2][15:8], s[3][7:0]};
    return o;
  endfunction

endpackage

// File: rtl/mixcolumn.sv
// Combinational (Inv)MixColumns on one 32-bit column, built from xtime chains.
// inv=0 applies the {02,03,01,01} circulant, inv=1 the {0e,0b,0d,09} circulant.
module mixcolumn
  import aes_pkg::*;
(
  input  aes_col_t din,
  input  logic     inv,
  output aes_col_t dout
);

  logic [3:0][7:0] a, x2, x4, x8;
  logic [3:0][7:0] m9, mb, md, me;
  logic [3:0][7:0] fwd, bwd;

  assign a = din;

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign x2[i] = xtime(a[i]);
    assign x4[i] = xtime(x2[i]);
    assign x8[i] = xtime(x4[i]);
    assign m9[i] = x8[i] ^ a[i];
    assign mb[i] = x8[i] ^ x2[i] ^ a[i];
    assign md[i] = x8[i] ^ x4[i] ^ a[i];
    assign me[i] = x8[i] ^ x4[i] ^ x2[i];
  end

  // 3*a is formed as xtime(a) ^ a.
  assign fwd[0] = x2[0] ^ (x2[1] ^ a[1]) ^ a[2] ^ a[3];
  assign fwd[1] = a[0] ^ x2[1] ^ (x2[2] ^ a[2]) ^ a[3];
  assign fwd[2] = a[0] ^ a[1] ^ x2[2] ^ (x2[3] ^ a[3]);
  assign fwd[3] = (x2[0] ^ a[0]) ^ a[1] ^ a[2] ^ x2[3];

  assign bwd[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
  assign bwd[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
  assign bwd[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
  assign bwd[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

  assign dout = inv ? bwd : fwd;

endmodule

// File: rtl/shiftmix.sv
// Two-register ShiftRows/MixColumns stage (forward) or InvMixColumns/InvShiftRows
// (inverse); per-beat mode bits travel with the data through both registers.
module shiftmix
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        encode,
  input  logic        skip_mix,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] in3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2,
  output logic [31:0] out3
);

  aes_state_t in_state, in_imix, s1_next, s1_data;
  aes_state_t s1_fmix, s2_next, s2_data;
  logic       s1_valid, s1_encode, s1_skip;
  logic       s1_en, s2_en;

  assign in_state = {in3, in2, in1, in0};

  for (genvar c = 0; c < 4; c++) begin : g_col
    mixcolumn u_imix (.din(in_state[c]), .inv(1'b1), .dout(in_imix[c]));
    mixcolumn u_fmix (.din(s1_data[c]),  .inv(1'b0), .dout(s1_fmix[c]));
  end

  assign s1_next = encode    ? shift_rows(in_state)
                 : skip_mix  ? in_state : in_imix;
  assign s2_next = !s1_encode ? inv_shift_rows(s1_data)
                 : s1_skip    ? s1_data : s1_fmix;

  // Handshake: a beat moves on any edge where valid & ready are both high.
  // out_valid, once raised, holds with stable data until out_ready; each
  // register advances when it is empty or the one after it advances, so
  // in_ready depends combinationally on out_ready.
  assign s2_en    = !out_valid | out_ready;
  assign s1_en    = !s1_valid | s2_en;
  assign in_ready = s1_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_encode <= 1'b0;
      s1_skip   <= 1'b0;
      s1_data   <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_encode <= encode;
        s1_skip   <= skip_mix;
        s1_data   <= s1_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s2_data   <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) s2_data <= s2_next;
    end
  end

  assign out0 = s2_data[0];
  assign out1 = s2_data[1];
  assign out2 = s2_data[2];
  assign out3 = s2_data[3];

endmodule

// File: tb/tb_shiftmix.sv
// Self-checking bench for shiftmix: directed vectors plus randomized streams
// scored against a byte-matrix GF(2^8) reference model.
module tb_shiftmix;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, encode, skip_mix;
  logic [31:0] in0, in1, in2, in3;
  logic        out_valid, out_ready;
  logic [31:0] out0, out1, out2, out3;

  typedef struct packed {
    logic [127:0] data;
    logic         enc;
    logic         skip;
  } beat_t;

  beat_t        src_q[$];
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  int           got_cyc[$];
  int           acc_cyc[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   occ      = 0;
  int   stall_err = 0;
  int   ir_err    = 0;
  int   stall_seen = 0;
  logic prev_stall = 1'b0;
  logic [127:0] prev_out;
  logic [127:0] cur_out;

  shiftmix dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .encode(encode), .skip_mix(skip_mix),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign cur_out = {out3, out2, out1, out0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || cur_out !== prev_out)) stall_err++;
      if (in_ready !== !(occ == 2 && !out_ready)) ir_err++;
      if (occ == 2 && !out_ready) stall_seen++;
      if (in_valid && in_ready) begin
        occ++;
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        occ--;
        got_q.push_back(cur_out);
        got_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur_out;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // row holds the first matrix row, coefficient j in byte j; rows are circulant.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic [31:0] row);
    logic [127:0] o;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(row[8*((k - r + 4) % 4) +: 8], s[32*c + 8*k +: 8]);
        o[32*c + 8*r +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] ref_shift(input logic [127:0] s, input int dir);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[32*c + 8*r +: 8] = s[32*((c + dir*r + 4) % 4) + 8*r +: 8];
    return o;
  endfunction

  function automatic logic [127:0] ref_xform(input logic [127:0] s, input logic enc, input logic skip);
    if (enc) return skip ? ref_shift(s, 1) : ref_mix(ref_shift(s, 1), 32'h01010302);
    else     return ref_shift(skip ? s : ref_mix(s, 32'h090d0b0e), -1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_beat(input logic [127:0] d, input logic enc, input logic skip);
    beat_t b;
    b.data = d;
    b.enc  = enc;
    b.skip = skip;
    src_q.push_back(b);
    exp_q.push_back(ref_xform(d, enc, skip));
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    acc_cyc.delete();
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic stream(input int pat, input int n_expect);
    int k;
    int budget;
    k = 0;
    budget = n_expect * 8 + 40;
    while ((src_q.size() != 0 || got_q.size() < n_expect) && k < budget) begin
      if (src_q.size() != 0) begin
        in_valid = 1'b1;
        {in3, in2, in1, in0} = src_q[0].data;
        encode   = src_q[0].enc;
        skip_mix = src_q[0].skip;
      end else begin
        in_valid = 1'b0;
        {in3, in2, in1, in0} = {$urandom, $urandom, $urandom, $urandom};
        encode   = 1'($urandom_range(0, 1));
        skip_mix = 1'($urandom_range(0, 1));
      end
      case (pat)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 4 == 0) || (k % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (in_valid && in_ready) void'(src_q.pop_front());
      @(posedge clk);
      #1;
      k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    src_q.delete();
  endtask

  task automatic score(input string name, input int n);
    n_checks++;
    if (got_q.size() !== n) $display("FAIL %s_count: got %0d beats, need %0d", name, got_q.size(), n);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL %s_beat%0d: got %h, need %h", name, i,
                 (i < got_q.size()) ? got_q[i] : 128'hx, exp_q[i]);
      else n_pass++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; encode = 1'b1; skip_mix = 1'b0;
    {in3, in2, in1, in0} = '0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, need 0", out_valid); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, need 1", in_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid_after: got %b, need 0", out_valid); else n_pass++;
    n_checks++;
    if (cur_out !== 128'h0) $display("FAIL reset_outs: got %h, need 0", cur_out); else n_pass++;
  endtask

  task automatic test_shiftrows_latency();
    logic [127:0] want;
    want = {32'h0b06010c, 32'h07020d08, 32'h030e0904, 32'h0f0a0500};
    in_valid = 1'b1; encode = 1'b1; skip_mix = 1'b1; out_ready = 1'b1;
    {in3, in2, in1, in0} = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL sr_accept: got in_ready %b, need 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL sr_early: got out_valid %b, need 0", out_valid); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL sr_latency: got out_valid %b, need 1", out_valid); else n_pass++;
    n_checks++;
    if (cur_out !== want) $display("FAIL sr_data: got %h, need %h", cur_out, want); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mixcolumns();
    clear_sb();
    push_beat({4{32'h455313db}}, 1'b1, 1'b0);
    push_beat({4{32'h5c220af2}}, 1'b1, 1'b0);
    push_beat({4{32'h01010101}}, 1'b1, 1'b0);
    exp_q.delete();
    exp_q.push_back({4{32'hbca14d8e}});
    exp_q.push_back({4{32'h9d58dc9f}});
    exp_q.push_back({4{32'h01010101}});
    stream(0, 3);
    score("mix", 3);
  endtask

  task automatic test_fips_round1();
    logic [127:0] key;
    logic [127:0] want;
    key  = {32'h05766c2a, 32'h3939a323, 32'hb12c5488, 32'h17fefaa0};
    want = {32'h49506a02, 32'h43ea5b6b, 32'h2b359f68, 32'hf27f9ca4};
    clear_sb();
    push_beat({32'h3052411e, 32'he55db4b8, 32'hf198bfe0, 32'hae1127d4}, 1'b1, 1'b0);
    stream(0, 1);
    n_checks++;
    if (got_q.size() != 1 || (got_q[0] ^ key) !== want)
      $display("FAIL fips_round1: got %h, need %h", (got_q.size() != 0) ? (got_q[0] ^ key) : 128'hx, want);
    else n_pass++;
  endtask

  task automatic test_roundtrip();
    logic [127:0] orig[$];
    logic         skips[$];
    logic [127:0] fwd[$];
    logic [127:0] d;
    logic         sk;
    clear_sb();
    for (int i = 0; i < 1000; i++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      sk = 1'($urandom_range(0, 1));
      orig.push_back(d);
      skips.push_back(sk);
      push_beat(d, 1'b1, sk);
    end
    stream(2, 1000);
    score("rt_fwd", 1000);
    fwd = got_q;
    clear_sb();
    for (int i = 0; i < 1000; i++) push_beat((i < fwd.size()) ? fwd[i] : 128'h0, 1'b0, skips[i]);
    exp_q = orig;
    stream(2, 1000);
    score("rt_inv", 1000);
    n_checks++;
    if (ir_err !== 0) $display("FAIL rt_in_ready: got %0d bad cycles, need 0", ir_err); else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_sb();
    stall_err = 0; ir_err = 0; stall_seen = 0;
    for (int i = 0; i < 8; i++)
      push_beat({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    stream(1, 8);
    score("bp", 8);
    n_checks++;
    if (stall_err !== 0) $display("FAIL bp_hold: got %0d unstable stall cycles, need 0", stall_err); else n_pass++;
    n_checks++;
    if (ir_err !== 0) $display("FAIL bp_in_ready: got %0d bad cycles, need 0", ir_err); else n_pass++;
    n_checks++;
    if (stall_seen == 0) $display("FAIL bp_full: got %0d full-stall cycles, need >0", stall_seen); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_sb();
    for (int i = 0; i < 16; i++)
      push_beat({$urandom, $urandom, $urandom, $urandom}, 1'(i % 2), 1'($urandom_range(0, 1)));
    stream(0, 16);
    score("b2b", 16);
    n_checks++;
    if (acc_cyc.size() != 16 || acc_cyc[15] - acc_cyc[0] != 15)
      $display("FAIL b2b_accept_span: got %0d, need 15", (acc_cyc.size() == 16) ? acc_cyc[15] - acc_cyc[0] : -1);
    else n_pass++;
    n_checks++;
    if (got_cyc.size() != 16 || got_cyc[15] - got_cyc[0] != 15)
      $display("FAIL b2b_output_span: got %0d, need 15", (got_cyc.size() == 16) ? got_cyc[15] - got_cyc[0] : -1);
    else n_pass++;
    n_checks++;
    if (got_cyc.size() == 0 || acc_cyc.size() == 0 || got_cyc[0] - acc_cyc[0] != 2)
      $display("FAIL b2b_fill: got %0d, need 2",
               (got_cyc.size() != 0 && acc_cyc.size() != 0) ? got_cyc[0] - acc_cyc[0] : -1);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    clear_sb();
    out_ready = 1'b0;
    in_valid = 1'b1; encode = 1'b1; skip_mix = 1'b0;
    {in3, in2, in1, in0} = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    {in3, in2, in1, in0} = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL rst_full: got out_valid %b in_ready %b, need 1 0", out_valid, in_ready);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_async: got out_valid %b, need 0", out_valid); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || cur_out !== 128'h0)
      $display("FAIL rst_release: got in_ready %b outs %h, need 1 0", in_ready, cur_out);
    else n_pass++;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() !== 0) $display("FAIL rst_stale: got %0d beats, need 0", got_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_shiftrows_latency();
    test_mixcolumns();
    test_fips_round1();
    test_roundtrip();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
